// File: rtl/corr_pkg.sv
// Shared constants for the correlator frame packer: frame markers, FSM state
// encoding and the derived bytes-per-word helper.
package corr_pkg;

  localparam logic [7:0] CORR_SYNC0 = 8'hA5;
  localparam logic [7:0] CORR_SYNC1 = 8'h5A;

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_SYNC0   = 3'd1;
  localparam logic [STATE_W-1:0] ST_SYNC1   = 3'd2;
  localparam logic [STATE_W-1:0] ST_SEQ     = 3'd3;
  localparam logic [STATE_W-1:0] ST_PAYLOAD = 3'd4;
  localparam logic [STATE_W-1:0] ST_CSUM    = 3'd5;

  function automatic int word_bytes(input int resolution);
    return (resolution + 7) / 8;
  endfunction

endpackage

// File: rtl/corr_byte_mux.sv
// Combinational selector returning payload byte byte_idx of the snapshot buffer.
// Words are emitted little-endian with the unused upper pad bits forced to zero.
module corr_byte_mux #(
  parameter int RESOLUTION = 12,
  parameter int NUM_WORDS  = 36,
  parameter int WORD_BYTES = 2,
  parameter int IDX_W      = 7
) (
  input  logic [NUM_WORDS*RESOLUTION-1:0] buffer,
  input  logic [IDX_W-1:0]                byte_idx,
  output logic [7:0]                      byte_data
);

  localparam int TOTAL = NUM_WORDS * WORD_BYTES;

  logic [TOTAL*8-1:0] flat;

  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_word
    logic [WORD_BYTES*8-1:0] padded;
    assign padded = (WORD_BYTES*8)'(buffer[k*RESOLUTION +: RESOLUTION]);
    assign flat[k*WORD_BYTES*8 +: WORD_BYTES*8] = padded;
  end

  // Out-of-range indices (past the last payload byte) read as zero.
  always_comb begin
    byte_data = 8'h00;
    for (int i = 0; i < TOTAL; i++) begin
      if (byte_idx == IDX_W'(i)) begin
        byte_data = flat[i*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/corr_frame_packer.sv
// Serialises one correlator snapshot per integration period into a framed byte
// stream (sync, sequence, payload, checksum) over a valid/ready byte handshake.
module corr_frame_packer
  import corr_pkg::*;
#(
  parameter int         RESOLUTION = 12,
  parameter int         NUM_WORDS  = 36,
  parameter logic [7:0] SYNC0      = CORR_SYNC0,
  parameter logic [7:0] SYNC1      = CORR_SYNC1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic                            snap_valid,
  input  logic [NUM_WORDS*RESOLUTION-1:0] snap_data,
  output logic [7:0]                      tx_data,
  output logic                            tx_valid,
  input  logic                            tx_ready,
  output logic                            busy,
  output logic                            frame_done,
  output logic                            overrun,
  input  logic                            clear_overrun
);

  localparam int WORD_BYTES = word_bytes(RESOLUTION);
  localparam int TOTAL      = NUM_WORDS * WORD_BYTES;
  localparam int IDX_W      = $clog2(TOTAL + 1);

  logic [STATE_W-1:0]              state;
  logic [7:0]                      seq;
  logic [7:0]                      checksum;
  logic [NUM_WORDS*RESOLUTION-1:0] buffer;
  logic [IDX_W-1:0]                byte_idx;
  logic [7:0]                      mux_byte;
  logic                            transfer;
  logic                            accept;
  logic                            drop;

  assign busy     = (state != ST_IDLE);
  assign transfer = tx_valid && tx_ready;
  // A new snapshot fits either when idle or exactly as the checksum byte leaves.
  assign accept   = snap_valid && enable &&
                    ((state == ST_IDLE) || ((state == ST_CSUM) && transfer));
  assign drop     = snap_valid && enable && busy && !accept;

  corr_byte_mux #(
    .RESOLUTION (RESOLUTION),
    .NUM_WORDS  (NUM_WORDS),
    .WORD_BYTES (WORD_BYTES),
    .IDX_W      (IDX_W)
  ) u_byte_mux (
    .buffer    (buffer),
    .byte_idx  (byte_idx),
    .byte_data (mux_byte)
  );

  // byte_idx always points at the next payload byte to load into tx_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      tx_valid   <= 1'b0;
      tx_data    <= 8'h00;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      seq        <= 8'h00;
      checksum   <= 8'h00;
      buffer     <= '0;
      byte_idx   <= '0;
    end else begin
      frame_done <= 1'b0;

      if (drop) begin
        overrun <= 1'b1;
      end else if (clear_overrun) begin
        overrun <= 1'b0;
      end

      if (accept) begin
        buffer   <= snap_data;
        byte_idx <= '0;
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= ST_SYNC0;
            tx_valid <= 1'b1;
            tx_data  <= SYNC0;
          end
        end
        ST_SYNC0: begin
          if (transfer) begin
            state   <= ST_SYNC1;
            tx_data <= SYNC1;
          end
        end
        ST_SYNC1: begin
          if (transfer) begin
            state   <= ST_SEQ;
            tx_data <= seq;
          end
        end
        ST_SEQ: begin
          if (transfer) begin
            state    <= ST_PAYLOAD;
            checksum <= seq;
            tx_data  <= mux_byte;
            byte_idx <= byte_idx + IDX_W'(1);
          end
        end
        ST_PAYLOAD: begin
          if (transfer) begin
            checksum <= checksum + tx_data;
            if (byte_idx == IDX_W'(TOTAL)) begin
              state   <= ST_CSUM;
              tx_data <= checksum + tx_data;
            end else begin
              tx_data  <= mux_byte;
              byte_idx <= byte_idx + IDX_W'(1);
            end
          end
        end
        ST_CSUM: begin
          if (transfer) begin
            frame_done <= 1'b1;
            seq        <= seq + 8'd1;
            if (accept) begin
              state   <= ST_SYNC0;
              tx_data <= SYNC0;
            end else begin
              state    <= ST_IDLE;
              tx_valid <= 1'b0;
              tx_data  <= 8'h00;
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_corr_frame_packer.sv
// Self-checking bench for corr_frame_packer (2 words x 12 bits): random snapshots
// and backpressure compared against a frame-level reference model.
module tb_corr_frame_packer;

  localparam int RES   = 12;
  localparam int NW    = 2;
  localparam int WB    = (RES + 7) / 8;
  localparam int DW    = NW * RES;
  localparam int GUARD = 5000;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic          snap_valid;
  logic [DW-1:0] snap_data;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          busy;
  logic          frame_done;
  logic          overrun;
  logic          clear_overrun;

  int         testsRun    = 0;
  int         testsFailed = 0;
  int         doneCount   = 0;
  logic [7:0] expSeq      = 8'h00;
  logic [7:0] lastSeqByte = 8'h00;
  bit         randReady   = 1'b0;
  logic [7:0] got[$];
  logic [7:0] exp[$];
  logic       prevHold    = 1'b0;
  logic [7:0] prevData    = 8'h00;

  corr_frame_packer #(
    .RESOLUTION (RES),
    .NUM_WORDS  (NW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .snap_valid    (snap_valid),
    .snap_data     (snap_data),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .busy          (busy),
    .frame_done    (frame_done),
    .overrun       (overrun),
    .clear_overrun (clear_overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference frame: markers, sequence, little-endian zero-padded words, mod-256 sum.
  function automatic void expectFrame(input logic [DW-1:0] d);
    logic [7:0]    sum;
    logic [15:0]   word;
    logic [7:0]    b8;
    sum = expSeq;
    exp.push_back(8'hA5);
    exp.push_back(8'h5A);
    exp.push_back(expSeq);
    for (int w = 0; w < NW; w++) begin
      word = 16'(d[w*RES +: RES]);
      for (int b = 0; b < WB; b++) begin
        b8 = word[b*8 +: 8];
        exp.push_back(b8);
        sum = sum + b8;
      end
    end
    exp.push_back(sum);
    expSeq = expSeq + 8'd1;
  endfunction

  // Byte monitor, handshake-hold checker and frame_done counter, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prevHold = 1'b0;
      end else begin
        if (prevHold) checkOutput("hold_stable", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, prevData});
        if (tx_valid && tx_ready) got.push_back(tx_data);
        if (frame_done) doneCount++;
        prevHold = tx_valid && !tx_ready;
        prevData = tx_data;
      end
    end
  end

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic applyStimulus(input logic [DW-1:0] d, input bit en, input bit expectAccept, input bit clr);
    snap_data     = d;
    snap_valid    = 1'b1;
    enable        = en;
    clear_overrun = clr;
    @(posedge clk);
    #1;
    snap_valid    = 1'b0;
    enable        = 1'b1;
    clear_overrun = 1'b0;
    if (expectAccept) begin
      checkOutput("accept_latency", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hA5});
      expectFrame(d);
    end
  endtask

  task automatic waitAndCompare(input string tag, input int frames);
    int guard = 0;
    while ((got.size() < exp.size() || busy) && guard < GUARD) begin
      @(posedge clk);
      #1;
      guard++;
    end
    @(posedge clk);
    #1;
    checkOutput({tag, "_timeout"}, 32'(guard < GUARD), 32'd1);
    checkOutput({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      checkOutput({tag, "_byte"}, {24'd0, got[i]}, {24'd0, exp[i]});
    end
    checkOutput({tag, "_frame_done"}, 32'(doneCount), 32'(frames));
    lastSeqByte = (got.size() > 2) ? got[2] : 8'hFF;
    got.delete();
    exp.delete();
    doneCount = 0;
  endtask

  task automatic waitBytes(input int n);
    int guard = 0;
    while (got.size() < n && guard < GUARD) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("wait_bytes_timeout", 32'(guard < GUARD), 32'd1);
  endtask

  initial begin
    logic [DW-1:0] d;
    rst_n         = 1'b1;
    enable        = 1'b1;
    snap_valid    = 1'b0;
    snap_data     = '0;
    clear_overrun = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_tx_valid", {31'd0, tx_valid}, 32'd0);
    checkOutput("reset_tx_data", {24'd0, tx_data}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_frame_done", {31'd0, frame_done}, 32'd0);
    checkOutput("reset_overrun", {31'd0, overrun}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame against hand-computed bytes.
    applyStimulus({12'hABC, 12'h123}, 1'b1, 1'b0, 1'b0);
    checkOutput("basic_latency", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hA5});
    exp = '{8'hA5, 8'h5A, 8'h00, 8'h23, 8'h01, 8'hBC, 8'h0A, 8'hEA};
    expSeq = 8'h01;
    waitAndCompare("basic", 1);

    // Random snapshots under random backpressure.
    randReady = 1'b1;
    for (int f = 0; f < 6; f++) begin
      applyStimulus(DW'($urandom), 1'b1, 1'b1, 1'b0);
      waitAndCompare("backpressure", 1);
    end

    // Drop during PAYLOAD, then clear.
    applyStimulus(DW'($urandom), 1'b1, 1'b1, 1'b0);
    waitBytes(4);
    checkOutput("overrun_before_drop", {31'd0, overrun}, 32'd0);
    applyStimulus(DW'($urandom), 1'b1, 1'b0, 1'b0);
    checkOutput("overrun_set", {31'd0, overrun}, 32'd1);
    waitAndCompare("overrun_frame", 1);
    checkOutput("overrun_sticky", {31'd0, overrun}, 32'd1);
    clear_overrun = 1'b1;
    @(posedge clk);
    #1;
    clear_overrun = 1'b0;
    checkOutput("overrun_cleared", {31'd0, overrun}, 32'd0);

    // Drop coinciding with clear: set wins.
    applyStimulus(DW'($urandom), 1'b1, 1'b1, 1'b0);
    applyStimulus(DW'($urandom), 1'b1, 1'b0, 1'b1);
    checkOutput("overrun_set_wins", {31'd0, overrun}, 32'd1);
    waitAndCompare("set_wins_frame", 1);
    clear_overrun = 1'b1;
    @(posedge clk);
    #1;
    clear_overrun = 1'b0;
    checkOutput("overrun_cleared2", {31'd0, overrun}, 32'd0);

    // Snapshot with enable low is ignored.
    applyStimulus(DW'($urandom), 1'b0, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("disabled_no_bytes", 32'(got.size()), 32'd0);
    checkOutput("disabled_busy", {31'd0, busy}, 32'd0);
    checkOutput("disabled_overrun", {31'd0, overrun}, 32'd0);

    // Back-to-back: with ready held high the checksum leaves 8 edges after acceptance.
    randReady = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(DW'($urandom), 1'b1, 1'b1, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    applyStimulus(DW'($urandom), 1'b1, 1'b1, 1'b0);
    checkOutput("b2b_no_overrun", {31'd0, overrun}, 32'd0);
    waitAndCompare("b2b", 2);

    // Reset mid-PAYLOAD aborts the frame and restarts the sequence.
    randReady = 1'b1;
    applyStimulus(DW'($urandom), 1'b1, 1'b1, 1'b0);
    waitBytes(4);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_tx_valid", {31'd0, tx_valid}, 32'd0);
    checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
    got.delete();
    exp.delete();
    doneCount = 0;
    expSeq = 8'h00;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(DW'($urandom), 1'b1, 1'b1, 1'b0);
    waitAndCompare("after_reset", 1);
    checkOutput("after_reset_seq", {24'd0, lastSeqByte}, 32'd0);

    // 256 more frames: the 257th since reset carries sequence 00 again.
    for (int f = 1; f < 257; f++) begin
      randReady = (f % 16 == 0);
      d = DW'($urandom);
      applyStimulus(d, 1'b1, 1'b1, 1'b0);
      waitAndCompare("wrap", 1);
    end
    checkOutput("wrap_seq", {24'd0, lastSeqByte}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/corr_frame_packer.md
Name: corr_frame_packer

Overview:
- Downstream of the correlator/counter array. Accepts one latched snapshot of all correlation and pulse-count words per integration period.
- Serialises the snapshot into a framed byte stream: sync, sequence, payload and checksum.
- Feeds the UART transmitter through a byte valid/ready handshake. Replaces raw wide-word shifting with a self-delimiting, checkable frame the host can resynchronise on.

Parameters:
- RESOLUTION, 12, bit width of each counter word.
- NUM_WORDS, 36, number of words per snapshot (correlator taps plus input counters).
- WORD_BYTES, (RESOLUTION+7)/8, bytes emitted per word (derived; do not override).
- SYNC0, 8'hA5, first frame marker byte.
- SYNC1, 8'h5A, second frame marker byte.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  snapshot acceptance enable (transmit_enable).
- snap_valid  in  1  one-cycle strobe: snap_data holds a new snapshot.
- snap_data  in  NUM_WORDS*RESOLUTION  snapshot; word k at [k*RESOLUTION +: RESOLUTION].
- tx_data  out  8  byte to UART transmitter.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  UART transmitter accepts byte this cycle.
- busy  out  1  frame in progress (state != IDLE).
- frame_done  out  1  one-cycle pulse on acceptance of the checksum byte.
- overrun  out  1  sticky: a snapshot was dropped.
- clear_overrun  in  1  synchronous clear of overrun.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; tx_valid=0, tx_data=0, busy=0, frame_done=0, overrun=0.
  - seq=0, checksum=0, snapshot buffer=0.
  - Reset mid-frame aborts the frame immediately; no partial-frame recovery.
- Snapshot acceptance occurs when snap_valid && enable and either:
  - state==IDLE, or
  - state==CSUM && tx_valid && tx_ready (back-to-back frames).
- On acceptance:
  - snap_data is copied into an internal buffer.
  - Next cycle: tx_valid=1, tx_data=SYNC0, state=SYNC0. Latency is exactly 1 cycle.
- Drops and enable:
  - snap_valid && enable while busy and not in the acceptance window: snapshot dropped, overrun set next cycle.
  - snap_valid with enable=0: ignored, no overrun.
  - enable falling mid-frame does not abort the frame.
- Handshake:
  - A byte transfers when tx_valid && tx_ready.
  - tx_data and tx_valid are held stable until the transfer.
  - tx_valid never deasserts without a transfer, except on reset.
  - The next byte is presented the cycle after the transfer, so there are no idle gaps inside a frame.
- States and transitions (advance only on transfer):
  - IDLE: no output.
  - SYNC0: SYNC0 -> SYNC1.
  - SYNC1: SYNC1 -> SEQ.
  - SEQ: emits seq; checksum := seq -> PAYLOAD.
  - PAYLOAD: byte index b = 0..NUM_WORDS*WORD_BYTES-1; word b/WORD_BYTES, byte b%WORD_BYTES, little-endian, upper pad bits zero; checksum += byte; after last -> CSUM.
  - CSUM: emits checksum (8-bit sum mod 256 of seq and all payload bytes); on transfer frame_done=1 for one cycle, seq += 1 (wraps 255->0), then state -> IDLE (or SYNC0 if a snapshot was accepted the same cycle).
- Frame length is 4 + NUM_WORDS*WORD_BYTES bytes.
- Overrun:
  - clear_overrun and a simultaneous drop in the same cycle: overrun ends set (set wins).
  - Sequence gaps seen by the host also indicate drops.
- The buffer is not updated during a frame, so payload bytes always belong to one snapshot.

Decomposition:
- Shared package (corr_pkg):
  - SYNC0/SYNC1 constants.
  - State encoding for IDLE, SYNC0, SYNC1, SEQ, PAYLOAD, CSUM.
  - WORD_BYTES function.
- Sub-module: corr_byte_mux, a combinational selector returning byte b of the buffer.
- The checksum accumulator and FSM remain in corr_frame_packer.

Test Plan:
- Basic frame (NUM_WORDS=2, RESOLUTION=12, words 0x123, 0xABC, tx_ready=1):
  - Stimulus: accept the snapshot.
  - Required: bytes A5,5A,00,23,01,BC,0A,EA; frame_done pulses on EA; seq becomes 1.
- Backpressure:
  - Stimulus: tx_ready toggled pseudo-randomly.
  - Required: identical byte sequence; tx_data stable while tx_valid && !tx_ready.
- Overrun and enable gating:
  - Stimulus: second snap_valid during PAYLOAD.
  - Required: dropped; overrun=1; frame content unchanged; clear_overrun returns it to 0.
  - Stimulus: snap_valid with enable=0.
  - Required: nothing emitted.
- Back-to-back:
  - Stimulus: snap_valid in the same cycle as the CSUM transfer.
  - Required: next cycle tx_data=A5; seq incremented; no overrun.
- Sequence wrap:
  - Stimulus: 257 frames.
  - Required: seq byte of frame 257 is 00; checksums correct.
- Reset mid-PAYLOAD:
  - Stimulus: rst_n low asynchronously.
  - Required: tx_valid=0, busy=0 immediately; next accepted frame starts with A5 and seq 00.
